// File: rtl/accelbrot_com_block_arb.sv
// Block arbiter that picks one requester and loads its block into the word serializer.
// Define ACCELBROT_COM_ARB_RR_EN for round-robin grant; the default build uses fixed priority.
module accelbrot_com_block_arb #(
    parameter int NREQ   = 4,
    parameter int NWORDS = 8,
    parameter int WWIDTH = 34,
    parameter int GAP    = 0,
    localparam int BWIDTH = NWORDS * WWIDTH,
    localparam int SRC_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BWIDTH-1:0]   req_block,
    output logic [NREQ-1:0]          req_ready,
    output logic [BWIDTH-1:0]        blk_out,
    output logic                     blk_valid,
    output logic [SRC_W-1:0]         blk_src,
    output logic                     busy
);

    // state | meaning
    // IDLE  | waiting for a valid requester, grants combinationally
    // BUSY  | serializer draining the last block (plus gap), no grants

    localparam int              CNT_W    = $clog2(NWORDS + GAP);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NWORDS + GAP - 2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BWIDTH-1:0]  blk_q, blk_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic               valid_q, valid_d;

`ifdef ACCELBROT_COM_ARB_RR_EN
    // Holds the index where the next search begins (last grant + 1), so reset value 0
    // makes the very first search start at requester 0.
    logic [SRC_W-1:0]   ptr_q, ptr_d;
`endif

    logic               any_valid;
    logic               accept;
    logic [SRC_W-1:0]   gnt_idx;
    logic [NREQ-1:0]    gnt_oh;
    logic [BWIDTH-1:0]  sel_blk;

    always_comb begin : grant_select
`ifdef ACCELBROT_COM_ARB_RR_EN
        int dist;
        int best_dist;
        dist      = 0;
        best_dist = NREQ;
`endif
        gnt_idx   = '0;
        any_valid = |req_valid;
`ifdef ACCELBROT_COM_ARB_RR_EN
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                dist = i - int'(ptr_q);
                if (dist < 0) dist = dist + NREQ;
                if (dist < best_dist) begin
                    best_dist = dist;
                    gnt_idx   = SRC_W'(i);
                end
            end
        end
`else
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) gnt_idx = SRC_W'(i);
        end
`endif
        gnt_oh  = '0;
        sel_blk = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_oh[i] = any_valid && (gnt_idx == SRC_W'(i));
            if (gnt_oh[i]) sel_blk = req_block[i*BWIDTH +: BWIDTH];
        end
    end

    assign accept    = (state_q == IDLE) && any_valid && !rst;
    assign req_ready = accept ? gnt_oh : '0;

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        src_d   = src_q;
        valid_d = 1'b0;
`ifdef ACCELBROT_COM_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    blk_d   = sel_blk;
                    src_d   = gnt_idx;
                    valid_d = 1'b1;
`ifdef ACCELBROT_COM_ARB_RR_EN
                    ptr_d   = (gnt_idx == SRC_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
`ifdef ACCELBROT_COM_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            src_q   <= src_d;
            valid_q <= valid_d;
`ifdef ACCELBROT_COM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign blk_out   = blk_q;
    assign blk_valid = valid_q;
    assign blk_src   = src_q;
    assign busy      = (state_q == BUSY);

endmodule
